// File: rtl/video_burst_reader.sv
// video_burst_reader
//   Requests fixed-length bursts of packed RGB565 words from the DDR read
//   arbiter, buffers them in an internal FIFO and unpacks them into a
//   one-pixel-per-clock stream aligned to the display timing (de_in/vs_in).
//
// Ports
//   clk            pixel/system clock
//   rst            asynchronous active-low reset
//   vs_in, de_in   display vsync (active high) / data enable for this tile
//   rd_req         burst request, held until rd_ack
//   trans_id       request ID (IMAGE_TAG)
//   rd_ack         arbiter accepts request (one-cycle pulse)
//   rd_data_in     returned data word, pixel 0 in bits [15:0]
//   rd_data_valid  rd_data_in valid, BURST_LEN pulses per acked request
//   rgb565_out     output pixel (1 clk latency)
//   de_out, vs_out de_in / vs_in delayed 1 clk
//   underflow      sticky: pixel demanded with FIFO empty; cleared on vsync rise
//   underflow_cnt  (VIDEO_READER_UFCNT_EN only) underflowed pixels this frame
//
// Optional feature macro: VIDEO_READER_UFCNT_EN
module video_burst_reader #(
  parameter int         DQ_WIDTH     = 32,
  parameter int         BURST_LEN    = 16,
  parameter int         FIFO_AW      = 5,
  parameter int         VIDEO_WIDTH  = 320,
  parameter int         VIDEO_HEIGHT = 180,
  parameter logic [3:0] IMAGE_TAG    = 4'd1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vs_in,
  input  logic                  de_in,
  output logic                  rd_req,
  output logic [3:0]            trans_id,
  input  logic                  rd_ack,
  input  logic [DQ_WIDTH*8-1:0] rd_data_in,
  input  logic                  rd_data_valid,
  output logic [15:0]           rgb565_out,
  output logic                  de_out,
  output logic                  vs_out,
`ifdef VIDEO_READER_UFCNT_EN
  output logic [15:0]           underflow_cnt,
`endif
  output logic                  underflow
);

  localparam int DW          = DQ_WIDTH * 8;
  localparam int PPW         = DQ_WIDTH / 2;
  localparam int PW          = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int DEPTH       = 2 ** FIFO_AW;
  localparam int FRAME_WORDS = VIDEO_WIDTH * VIDEO_HEIGHT / PPW;
  localparam int RW          = $clog2(FRAME_WORDS + BURST_LEN + 1);
  localparam int CW          = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RECV, S_DRAIN} state_t;

  logic [DW-1:0]      r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic [RW-1:0]      r_req_words;
  logic [CW-1:0]      r_word_cnt;
  logic [PW-1:0]      r_pix_idx;
  state_t             r_state;
  logic               r_drain_pend;
  logic               r_rd_req;
  logic [3:0]         r_trans_id;
  logic [15:0]        r_rgb;
  logic               r_vs_d, r_de_d, r_underflow;

  logic               w_pos_vs, w_empty, w_take, w_pix_last, w_pop;
  logic               w_wr, w_last_word, w_can_req;
  logic [FIFO_AW:0]   w_free;
  logic [DW-1:0]      w_head, w_shifted;

  assign w_pos_vs    = vs_in & ~r_vs_d;
  assign w_empty     = (r_count == '0);
  assign w_take      = de_in & ~w_empty;
  assign w_pix_last  = (r_pix_idx == PW'(PPW - 1));
  assign w_pop       = w_take & w_pix_last & ~w_pos_vs;
  // Nothing is outstanding while IDLE, so free space is depth minus occupancy.
  assign w_free      = (FIFO_AW + 1)'(DEPTH) - r_count;
  assign w_can_req   = (w_free >= (FIFO_AW + 1)'(BURST_LEN)) &&
                       (r_req_words < RW'(FRAME_WORDS));
  assign w_wr        = (r_state == S_RECV) & rd_data_valid & ~w_pos_vs;
  assign w_last_word = (r_word_cnt == CW'(BURST_LEN - 1));
  assign w_head      = r_mem[r_rd_ptr];
  assign w_shifted   = w_head >> {r_pix_idx, 4'b0000};

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= rd_data_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_pos_vs) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A request still pending at vsync belongs to the old frame: its burst is
  // drained when it is finally acked and is not counted in req_words.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_rd_req     <= 1'b0;
      r_trans_id   <= '0;
      r_req_words  <= '0;
      r_word_cnt   <= '0;
      r_drain_pend <= 1'b0;
    end else begin
      r_trans_id <= IMAGE_TAG;
      if (w_pos_vs) r_req_words <= '0;
      case (r_state)
        S_IDLE: begin
          if (!w_pos_vs && w_can_req) begin
            r_state  <= S_REQ;
            r_rd_req <= 1'b1;
          end
        end
        S_REQ: begin
          if (w_pos_vs) r_drain_pend <= 1'b1;
          if (rd_ack) begin
            r_rd_req   <= 1'b0;
            r_word_cnt <= '0;
            if (r_drain_pend || w_pos_vs) begin
              r_state      <= S_DRAIN;
              r_drain_pend <= 1'b0;
            end else begin
              r_state     <= S_RECV;
              r_req_words <= r_req_words + RW'(BURST_LEN);
            end
          end
        end
        S_RECV: begin
          if (rd_data_valid) begin
            r_word_cnt <= r_word_cnt + 1'b1;
            if (w_last_word)   r_state <= S_IDLE;
            else if (w_pos_vs) r_state <= S_DRAIN;
          end else if (w_pos_vs) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (rd_data_valid) begin
            r_word_cnt <= r_word_cnt + 1'b1;
            if (w_last_word) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef VIDEO_READER_UFCNT_EN
  logic [15:0] r_uf_cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                   r_uf_cnt <= '0;
    else if (w_pos_vs)                          r_uf_cnt <= '0;
    else if (de_in && w_empty && r_uf_cnt != '1) r_uf_cnt <= r_uf_cnt + 1'b1;
  end
  assign underflow_cnt = r_uf_cnt;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vs_d      <= 1'b0;
      r_de_d      <= 1'b0;
      r_rgb       <= '0;
      r_pix_idx   <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_vs_d <= vs_in;
      r_de_d <= de_in;
      r_rgb  <= w_take ? w_shifted[15:0] : 16'h0000;
      if (w_pos_vs)    r_pix_idx <= '0;
      else if (w_take) r_pix_idx <= w_pix_last ? '0 : r_pix_idx + 1'b1;
      if (w_pos_vs)               r_underflow <= 1'b0;
      else if (de_in && w_empty)  r_underflow <= 1'b1;
    end
  end

  assign rd_req     = r_rd_req;
  assign trans_id   = r_trans_id;
  assign rgb565_out = r_rgb;
  assign de_out     = r_de_d;
  assign vs_out     = r_vs_d;
  assign underflow  = r_underflow;

endmodule
